// File: rtl/signed_div_unit.sv
// signed_div_unit: sequential WIDTH-bit signed divider, restoring, MIPS signs.
// Ports: clk, reset(active-low async), a, b, start -> quotient, remainder, done, div_by_zero, busy.
module signed_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH:0]   dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             qneg_q;
  logic             rneg_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] res_q;
  logic             done_q;
  logic             dbz_q;
  logic             busy_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shf_d;
  logic [WIDTH-1:0] sub_d;
  logic             ge_d;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // Remainder can reach 2*|b|-1, hence the extra bit
  // before the trial subtract; the kept result always
  // fits back into WIDTH bits.
  assign shf_d = {rem_q, dvd_q[WIDTH-1]};
  assign ge_d  = shf_d >= dvs_q;
  assign sub_d = WIDTH'(shf_d - dvs_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quo_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (b == '0) begin
              dbz_q   <= 1'b1;
              quo_q   <= '0;
              res_q   <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              dvd_q   <= a_mag;
              dvs_q   <= {1'b0, b_mag};
              rem_q   <= '0;
              cnt_q   <= '0;
              qneg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
              rneg_q  <= a[WIDTH-1];
              dbz_q   <= 1'b0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          rem_q <= ge_d ? sub_d : shf_d[WIDTH-1:0];
          dvd_q <= {dvd_q[WIDTH-2:0], ge_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quo_q   <= qneg_q ? -dvd_q : dvd_q;
          res_q   <= rneg_q ? -rem_q : rem_q;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign quotient    = quo_q;
  assign remainder   = res_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;

endmodule

// File: doc/signed_div_unit.md
# signed_div_unit

Sequential 32-bit signed divider serving the CPU's `DivStart` / `div_done` handshake for `div`.
- Accepts a start pulse with dividend and divisor, runs a 32-iteration restoring algorithm on magnitudes, then applies MIPS sign rules.
- Returns quotient and remainder for the HI/LO write path, with a one-cycle done pulse.
- Flags division by zero without iterating.

## Interface
Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low (0 = reset); clears all state immediately.
- a  input  WIDTH  dividend, signed two's complement; sampled only in the start cycle.
- b  input  WIDTH  divisor, signed two's complement; sampled only in the start cycle.
- start  input  1  request; honoured only in IDLE.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; sign follows the dividend.
- done  output  1  one-cycle pulse; quotient/remainder/div_by_zero valid from this cycle.
- div_by_zero  output  1  set with done when the sampled b was 0; held until the next accepted start.
- busy  output  1  high from the cycle after start is accepted through the done cycle.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE, start=1, b≠0:
  - Latch |a| into the dividend shift register.
  - Latch |b| into the divisor register, WIDTH+1 bits wide so |0x80000000| is exact.
  - Latch sign_q = a[31]^b[31] and sign_r = a[31].
  - Clear the partial remainder and iteration counter, clear div_by_zero, go to RUN.
- IDLE, start=1, b=0:
  - Set div_by_zero=1, quotient=0, remainder=0, go to DONE.
- RUN, one iteration per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter increments 0..WIDTH-1; after the iteration with counter = WIDTH-1, go to FIX.
- FIX:
  - quotient = sign_q ? -q_mag : q_mag.
  - remainder = sign_r ? -r_mag : r_mag.
  - Both wrap modulo 2^WIDTH. Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Output holding: quotient, remainder and div_by_zero hold their values in IDLE until the next accepted start. They are not cleared by done falling.
- Start while busy (RUN/FIX/DONE) is ignored; no queuing.
- Changes on a/b after the start cycle have no effect.
- Overflow case a=0x80000000, b=0xFFFFFFFF gives quotient=0x80000000 and remainder=0. No flag is raised.

## Timing
- Reset (reset=0, asynchronous) forces:
  - state=IDLE.
  - quotient=0, remainder=0, done=0, div_by_zero=0, busy=0.
  - All internal registers to 0.
- Reset mid-operation aborts without producing done. The first start after reset release is accepted normally.
- Cycle numbering: cycle 0 is the rising edge sampling start=1 in IDLE.
- Normal divide:
  - RUN occupies cycles 1..32, FIX is cycle 33, done=1 in cycle 34.
  - Total latency 34 cycles.
  - A new start is accepted earliest in cycle 35.
- Divide by zero: done=1 and div_by_zero=1 in cycle 1. A new start is accepted earliest in cycle 2.
- busy timing: high from cycle 1 through the done cycle inclusive, low in IDLE.
- done never asserts without a preceding accepted start.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- a=7, b=2, start pulse -> done in cycle 34; quotient=3, remainder=1, div_by_zero=0.
- Sign combinations, each checked at the done cycle:
  - a=-7, b=2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - a=7, b=-2 -> quotient=0xFFFFFFFD, remainder=1.
  - a=-7, b=-2 -> quotient=3, remainder=0xFFFFFFFF.
- a=100, b=0 -> done and div_by_zero both high in cycle 1; quotient=0, remainder=0. A following a=9, b=3 start clears div_by_zero and gives quotient=3, remainder=0 at cycle 34.
- a=0x80000000, b=0xFFFFFFFF -> quotient=0x80000000, remainder=0. Separately, a=0x80000000, b=1 -> quotient=0x80000000, remainder=0.
- Start a=20, b=3, then pulse start with a=50, b=5 in cycle 10 -> second start ignored; done only in cycle 34 with quotient=6, remainder=2. busy is high cycles 1..34.
- Start a=20, b=3, drive reset=0 asynchronously mid-cycle 15 -> all outputs 0 immediately; no done pulse. After release, a=20, b=3 yields quotient=6, remainder=2 after 34 cycles.
